// File: rtl/cpu_pkg.sv
// Shared load/store definitions: RV32I funct3 size codes and the LSU state encoding.
package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, replicated store data, extended load data and
// the illegal-access flag for one funct3/offset pair.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_we,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load,
    output logic        o_illegal
);

    logic [15:0] w_lane;

    // Only the low halfword of the shifted word is ever consumed by sub-word loads.
    assign w_lane = 16'(i_rword >> {i_off, 3'b000});

    always_comb begin
        o_be      = 4'b1111;
        o_wdata   = i_wdata;
        o_load    = i_rword;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be      = 4'b0001 << i_off;
                o_wdata   = {4{i_wdata[7:0]}};
                o_load    = (i_funct3 == F3_B) ? {{24{w_lane[7]}}, w_lane[7:0]}
                                               : {24'b0, w_lane[7:0]};
                o_illegal = i_we & i_funct3[2];
            end
            F3_H, F3_HU: begin
                o_be      = 4'b0011 << i_off;
                o_wdata   = {2{i_wdata[15:0]}};
                o_load    = (i_funct3 == F3_H) ? {{16{w_lane[15]}}, w_lane}
                                               : {16'b0, w_lane};
                o_illegal = i_off[0] | (i_we & i_funct3[2]);
            end
            F3_W: begin
                o_illegal = |i_off;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory access per request, registered handshake to memory,
// formatted load result and fault reporting for misaligned/illegal accesses and timeouts.
module lsu
    import cpu_pkg::*;
#(
    parameter int n    = 32,
    parameter int dlen = 8,
    parameter int TMO  = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [n-1:0]    addr,
    input  logic [n-1:0]    wdata,
    output logic [n-1:0]    rdata,
    output logic            done,
    output logic            fault,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [dlen-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [n-1:0]    mem_wdata,
    input  logic            mem_ready,
    input  logic [n-1:0]    mem_rdata
);

    localparam int CW = $clog2(TMO + 1);

    if (n != 32) begin : g_n_check
        $error("lsu: datapath width n must be 32");
    end

    lsu_state_t      r_state;
    logic            r_we;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic [CW-1:0]   r_cnt;

    logic [2:0]      w_f3;
    logic            w_we;
    logic [1:0]      w_off;
    logic [3:0]      w_be;
    logic [31:0]     w_lane_wdata;
    logic [31:0]     w_load;
    logic            w_illegal;
    logic            w_unused;

    // In IDLE the aligner sees the live request; afterwards it sees the latched one.
    assign w_f3  = (r_state == IDLE) ? funct3     : r_f3;
    assign w_we  = (r_state == IDLE) ? we         : r_we;
    assign w_off = (r_state == IDLE) ? addr[1:0]  : r_off;

    assign w_unused = ^{addr[n-1:dlen+2]};

    lsu_align u_align (
        .i_funct3  (w_f3),
        .i_we      (w_we),
        .i_off     (w_off),
        .i_wdata   (wdata),
        .i_rword   (mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_lane_wdata),
        .o_load    (w_load),
        .o_illegal (w_illegal)
    );

    assign stall = reset & req & (r_state != DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_f3      <= 3'b0;
            r_off     <= 2'b0;
            r_cnt     <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    if (req) begin
                        r_we      <= we;
                        r_f3      <= funct3;
                        r_off     <= addr[1:0];
                        r_cnt     <= '0;
                        mem_we    <= we;
                        mem_addr  <= addr[dlen+1:2];
                        mem_be    <= w_be;
                        mem_wdata <= w_lane_wdata;
                        if (w_illegal) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                            fault   <= 1'b1;
                            rdata   <= '0;
                            mem_req <= 1'b0;
                        end else begin
                            r_state <= ACCESS;
                            mem_req <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        fault   <= 1'b0;
                        mem_req <= 1'b0;
                        rdata   <= r_we ? '0 : w_load;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(TMO - 1)) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                        mem_req <= 1'b0;
                        rdata   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    fault   <= 1'b0;
                    mem_req <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses against a
// behavioural model of RV32I load/store lane rules.
module tb_lsu;
    import cpu_pkg::*;

    localparam int TMO = 15;

    logic        clock;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        fault;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    lsu #(.n(32), .dlen(8), .TMO(TMO)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .fault     (fault),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Reference model: what the instruction should do, from the RV32I rules.
    function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rw,
                                  output logic ill, output logic [3:0] be,
                                  output logic [31:0] mwd, output logic [31:0] rd);
        int o;
        logic is_b, is_h, is_w;
        logic [31:0] sh, b, h;
        o    = int'(a[1:0]);
        is_b = (f3 == 3'd0) || (f3 == 3'd4);
        is_h = (f3 == 3'd1) || (f3 == 3'd5);
        is_w = (f3 == 3'd2);
        ill  = !(is_b || is_h || is_w) || (w && f3 >= 3'd4) ||
               (is_h && (o % 2) != 0) || (is_w && o != 0);
        be   = is_b ? 4'(1 << o) : is_h ? 4'(3 << o) : 4'hF;
        mwd  = is_b ? (wd & 32'hFF) * 32'h0101_0101 :
               is_h ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        rd   = 32'h0;
        if (!w && !ill) begin
            sh = rw >> (8 * o);
            b  = sh & 32'hFF;
            h  = sh & 32'hFFFF;
            if (is_w)          rd = rw;
            else if (f3 == 3'd4) rd = b;
            else if (f3 == 3'd5) rd = h;
            else if (f3 == 3'd0) rd = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            else               rd = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
        end
    endfunction

    // Driver: one complete instruction; delay = ACCESS cycles before mem_ready (>=TMO: never).
    task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rw,
                             input int delay, input string tag);
        logic ill;
        logic [3:0] be;
        logic [31:0] mwd, rd, exp_rd;
        logic tmo;
        model(w, f3, a, wd, rw, ill, be, mwd, rd);
        tmo = !ill && (delay >= TMO);
        exp_q.push_back(tmo ? 32'h0 : rd);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        mem_ready = 1'b0; mem_rdata = $urandom;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s stall_idle act=%b exp=1", tag, stall); end
        tick;
        if (!ill) begin
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL %s mem_req act=%b exp=1", tag, mem_req); end
            n_checks++; if (mem_addr !== 8'((a >> 2) & 32'hFF)) begin n_fail++; $display("FAIL %s mem_addr act=%h exp=%h", tag, mem_addr, 8'((a >> 2) & 32'hFF)); end
            n_checks++; if (mem_be !== be) begin n_fail++; $display("FAIL %s mem_be act=%b exp=%b", tag, mem_be, be); end
            n_checks++; if (mem_we !== w) begin n_fail++; $display("FAIL %s mem_we act=%b exp=%b", tag, mem_we, w); end
            if (w) begin
                n_checks++; if (mem_wdata !== mwd) begin n_fail++; $display("FAIL %s mem_wdata act=%h exp=%h", tag, mem_wdata, mwd); end
            end
            n_checks++; if (done !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL %s access done=%b stall=%b exp 0/1", tag, done, stall); end
            for (int i = 0; i < delay && i < TMO - 1; i++) begin
                mem_rdata = $urandom;
                tick;
                n_checks++;
                if (mem_req !== 1'b1 || mem_be !== be || mem_addr !== 8'((a >> 2) & 32'hFF) ||
                    mem_we !== w || (w && mem_wdata !== mwd) || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s hold[%0d] req=%b be=%b addr=%h wd=%h done=%b exp req=1 be=%b wd=%h done=0",
                             tag, i, mem_req, mem_be, mem_addr, mem_wdata, done, be, mwd);
                end
            end
            if (!tmo) begin
                mem_ready = 1'b1;
                mem_rdata = rw;
            end
            tick;
            mem_ready = 1'b0;
        end
        // DONE cycle: scoreboard pop
        exp_rd = exp_q.pop_front();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s done act=%b exp=1", tag, done); end
        n_checks++; if (fault !== (ill || tmo)) begin n_fail++; $display("FAIL %s fault act=%b exp=%b", tag, fault, ill || tmo); end
        n_checks++; if (rdata !== exp_rd) begin n_fail++; $display("FAIL %s rdata act=%h exp=%h", tag, rdata, exp_rd); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s mem_req_done act=%b exp=0", tag, mem_req); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s stall_done act=%b exp=0", tag, stall); end
        req = 1'b0;
        tick;
        n_checks++; if (done !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL %s pulse done=%b fault=%b exp 0/0", tag, done, fault); end
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h0; wdata = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset stall act=%b exp=0", stall); end
        tick;
        n_checks++;
        if (rdata !== 32'h0 || done !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== 8'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset outputs rdata=%h done=%b fault=%b req=%b we=%b addr=%h be=%b wd=%h exp all 0",
                     rdata, done, fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
        req = 1'b0;
        reset = 1'b1;
        tick;
    endtask

    task automatic test_lw;
        do_access(1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, "lw_basic");
    endtask

    task automatic test_lb_lbu;
        do_access(1'b0, F3_B,  32'h13, 32'h0, 32'h8011_2233, 0, "lb");
        do_access(1'b0, F3_BU, 32'h13, 32'h0, 32'h8011_2233, 1, "lbu");
        do_access(1'b0, F3_H,  32'h02, 32'h0, 32'h8001_1234, 0, "lh");
        do_access(1'b0, F3_HU, 32'h02, 32'h0, 32'h8001_1234, 2, "lhu");
    endtask

    task automatic test_sh_wait;
        do_access(1'b1, F3_H, 32'h6, 32'h0000_ABCD, 32'h0, 3, "sh_wait");
        do_access(1'b1, F3_B, 32'h5, 32'h1234_56A7, 32'h0, 1, "sb");
        do_access(1'b1, F3_W, 32'h8, 32'hCAFE_F00D, 32'h0, 0, "sw");
    endtask

    task automatic test_illegal;
        do_access(1'b0, F3_W,   32'h2, 32'h0, 32'h0, 0, "lw_misaligned");
        do_access(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, "f3_011");
        do_access(1'b1, F3_BU,  32'h4, 32'h0, 32'h0, 0, "store_1xx");
        do_access(1'b0, F3_HU,  32'h3, 32'h0, 32'h0, 0, "lh_odd");
    endtask

    task automatic test_timeout;
        do_access(1'b0, F3_W, 32'h20, 32'h0, 32'h1111_2222, TMO, "timeout");
        do_access(1'b0, F3_W, 32'h24, 32'h0, 32'h3333_4444, 0, "after_timeout");
    endtask

    task automatic test_reset_mid_access;
        req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h40; mem_ready = 1'b0;
        tick;
        tick;
        tick;
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid mem_req act=%b exp=0", mem_req); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid stall act=%b exp=0", stall); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid done act=%b exp=0", done); end
        req = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        n_checks++; if (mem_req !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_release req=%b done=%b exp 0/0", mem_req, done); end
        do_access(1'b0, F3_B, 32'h41, 32'h0, 32'h0000_F700, 1, "after_reset");
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            logic        w;
            logic [2:0]  f3;
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            // Noise on mem_ready while idle must be ignored.
            mem_ready = 1'($urandom_range(0, 1));
            tick;
            n_checks++; if (mem_req !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rand_idle[%0d] req=%b done=%b exp 0/0", k, mem_req, done); end
            do_access(w, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_wait();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
